// File: rtl/geo_seq_pkg.sv
// Shared types and default parameters for the geometric-sequence generator.
package geo_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } geo_state_t;

  localparam int GEO_WIDTH    = 8;
  localparam int GEO_FACTOR_W = 4;
  localparam int GEO_CNT_W    = 8;
  localparam int GEO_INIT     = 1;

endpackage

// File: rtl/geo_seq_mul.sv
// Combinational step: next_term = term * factor, wrapping by default or
// saturating to all-ones when GEO_SEQ_SATURATE_EN is defined.
module geo_seq_mul
  import geo_seq_pkg::*;
#(
  parameter int WIDTH    = GEO_WIDTH,
  parameter int FACTOR_W = GEO_FACTOR_W
) (
  input  logic [WIDTH-1:0]    term,
  input  logic [FACTOR_W-1:0] factor,
  output logic [WIDTH-1:0]    next_term,
  output logic                ovf_now
);

  localparam int PW = WIDTH + FACTOR_W;

  logic [PW-1:0] product;

  // Full-width product so the bits above WIDTH reveal overflow.
  assign product = PW'(term) * PW'(factor);
  assign ovf_now = |product[PW-1:WIDTH];

`ifdef GEO_SEQ_SATURATE_EN
  assign next_term = ovf_now ? {WIDTH{1'b1}} : product[WIDTH-1:0];
`else
  assign next_term = product[WIDTH-1:0];
`endif

endmodule

// File: rtl/geo_seq_gen.sv
// Geometric-sequence generator: emits seed*factor^k on a valid/ready stream.
// Saturating arithmetic is selected with the GEO_SEQ_SATURATE_EN macro.
module geo_seq_gen
  import geo_seq_pkg::*;
#(
  parameter int               WIDTH    = GEO_WIDTH,
  parameter int               FACTOR_W = GEO_FACTOR_W,
  parameter int               CNT_W    = GEO_CNT_W,
  parameter logic [WIDTH-1:0] INIT     = WIDTH'(GEO_INIT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    seed,
  input  logic [FACTOR_W-1:0] factor,
  input  logic [CNT_W-1:0]    count,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  geo_state_t          state_q, state_d;
  logic [WIDTH-1:0]    term_q;
  logic [WIDTH-1:0]    next_term;
  logic [FACTOR_W-1:0] factor_q;
  logic [CNT_W-1:0]    remaining_q;
  logic                overflow_q;
  logic                ovf_now;
  logic                accept;
  logic                handshake;

  geo_seq_mul #(
    .WIDTH    (WIDTH),
    .FACTOR_W (FACTOR_W)
  ) u_mul (
    .term      (term_q),
    .factor    (factor_q),
    .next_term (next_term),
    .ovf_now   (ovf_now)
  );

  // Stream: a term transfers on any rising edge where out_valid && out_ready;
  // out_valid never drops and out_data never changes until that transfer.
  assign accept    = (state_q == IDLE) && start;
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (count != '0) ? RUN : DONE;
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && (remaining_q == CNT_W'(1))) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_q      <= INIT;
      factor_q    <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      overflow_q <= 1'b0;
      if (count != '0) begin
        term_q      <= seed;
        factor_q    <= factor;
        remaining_q <= count;
      end
    end else if (handshake) begin
      // The product after the last term is still checked for overflow.
      term_q      <= next_term;
      remaining_q <= remaining_q - CNT_W'(1);
      if (ovf_now) overflow_q <= 1'b1;
    end
  end

  assign out_data = term_q;
  assign overflow = overflow_q;

endmodule
